dac_spi_tx: RTL and testbench

//  Downstream stage of the DDS core: accepts DAC_WIDTH-bit sine samples and serialises each one as an SPI-style frame to an external DAC.
//  The frame format is {CTRL_WORD, sample}, sent MSB first.
//  A 1-entry holding register decouples the DDS sample rate from the frame rate; overruns are flagged, never stalled.

---
 rtl/dds_pkg.sv | 18 +
 rtl/dac_spi_clkdiv.sv | 36 +++
 rtl/dac_spi_tx.sv | 134 +++++++++++++
 tb/tb_dac_spi_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared defaults, FSM encoding and frame-size helper for the DDS DAC output path.
package dds_pkg;

    localparam int unsigned DEF_DAC_WIDTH  = 12;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_CTRL_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } spi_state_t;

    function automatic int unsigned frame_width(input int unsigned ctrl_w, input int unsigned dac_w);
        return ctrl_w + dac_w;
    endfunction

endpackage

// File: rtl/dac_spi_clkdiv.sv
// SCLK half-period divider: produces the serial clock level and half/bit boundary strobes while enabled.
module dac_spi_clkdiv #(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic half_tick_c,
    output logic bit_end_c
);

    localparam int unsigned CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // A bit ends on the half tick that closes the low phase.
    assign half_tick_c = en && (cnt == CNT_W'(SCLK_DIV - 1));
    assign bit_end_c   = half_tick_c && !sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (half_tick_c) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises DDS samples as {CTRL_WORD, sample} SPI frames to a DAC through a 1-entry holding register.
module dac_spi_tx
    import dds_pkg::*;
#(
    parameter int unsigned            DAC_WIDTH  = DEF_DAC_WIDTH,
    parameter int unsigned            CTRL_WIDTH = DEF_CTRL_WIDTH,
    parameter logic [CTRL_WIDTH-1:0]  CTRL_WORD  = '0,
    parameter int unsigned            SCLK_DIV   = 4,
    parameter int unsigned            GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DAC_WIDTH-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 dac_sclk,
    output logic                 dac_sync_n,
    output logic                 dac_din,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned FRAME_WIDTH = frame_width(CTRL_WIDTH, DAC_WIDTH);
    localparam int unsigned BIT_W       = $clog2(FRAME_WIDTH);
    localparam int unsigned GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    spi_state_t             state, state_d;
    logic [DAC_WIDTH-1:0]   hold, hold_d;
    logic                   hold_full, hold_full_d;
    logic [FRAME_WIDTH-1:0] shreg, shreg_d;
    logic [BIT_W-1:0]       bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt, gap_cnt_d;
    logic                   sync_n_d, din_d, busy_d, overrun_d;
    logic [FRAME_WIDTH-1:0] frame_c;
    logic                   half_tick_c, bit_end_c;

    assign sample_ready = !hold_full;
    assign frame_c      = {CTRL_WORD, hold};

    dac_spi_clkdiv #(
        .SCLK_DIV (SCLK_DIV)
    ) u_clkdiv (
        .clk         (clk),
        .rst         (rst),
        .en          (state == ST_SHIFT),
        .sclk        (dac_sclk),
        .half_tick_c (half_tick_c),
        .bit_end_c   (bit_end_c)
    );

    // Next-state: holding register runs independently of the shifter FSM.
    always_comb begin
        state_d     = state;
        hold_d      = hold;
        hold_full_d = hold_full;
        shreg_d     = shreg;
        bit_cnt_d   = bit_cnt;
        gap_cnt_d   = gap_cnt;
        sync_n_d    = dac_sync_n;
        din_d       = dac_din;
        overrun_d   = sample_valid && hold_full;

        if (sample_valid && !hold_full) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    shreg_d     = frame_c;
                    hold_full_d = 1'b0;
                    sync_n_d    = 1'b0;
                    din_d       = frame_c[FRAME_WIDTH-1];
                    bit_cnt_d   = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_end_c) begin
                    if (bit_cnt == BIT_W'(FRAME_WIDTH - 1)) begin
                        sync_n_d  = 1'b1;
                        din_d     = 1'b0;
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end else begin
                        // Rotate so the next bit sits at the MSB; din only moves at bit start.
                        shreg_d   = {shreg[FRAME_WIDTH-2:0], shreg[FRAME_WIDTH-1]};
                        din_d     = shreg[FRAME_WIDTH-2];
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold       <= '0;
            hold_full  <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dac_sync_n <= 1'b1;
            dac_din    <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            hold       <= hold_d;
            hold_full  <= hold_full_d;
            shreg      <= shreg_d;
            bit_cnt    <= bit_cnt_d;
            gap_cnt    <= gap_cnt_d;
            dac_sync_n <= sync_n_d;
            dac_din    <= din_d;
            busy       <= busy_d;
            overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: default instance and a fast instance share stimulus; frame-timing model plus scoreboard.
module tb_dac_spi_tx;

    localparam int FW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sample_in;
    logic        sample_valid;

    logic ready0, sclk0, sync0, din0, busy0, ovr0;
    logic ready1, sclk1, sync1, din1, busy1, ovr1;
    logic [1:0] ready, sclk, sync_n, din, busy, ovr;

    assign ready  = {ready1, ready0};
    assign sclk   = {sclk1, sclk0};
    assign sync_n = {sync1, sync0};
    assign din    = {din1, din0};
    assign busy   = {busy1, busy0};
    assign ovr    = {ovr1, ovr0};

    always #5 clk = ~clk;

    dac_spi_tx u_dut0 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(ready0), .dac_sclk(sclk0), .dac_sync_n(sync0), .dac_din(din0),
        .busy(busy0), .overrun(ovr0)
    );

    dac_spi_tx #(
        .DAC_WIDTH(12), .CTRL_WIDTH(4), .CTRL_WORD(4'h3), .SCLK_DIV(1), .GAP_CYCLES(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(ready1), .dac_sclk(sclk1), .dac_sync_n(sync1), .dac_din(din1),
        .busy(busy1), .overrun(ovr1)
    );

    int       p_div  [2] = '{4, 1};
    int       p_gap  [2] = '{2, 1};
    logic [3:0] p_ctrl [2] = '{4'h0, 4'h3};

    int total = 0;
    int bad   = 0;

    int  cyc;
    int  m_load [2];
    bit  m_has  [2];
    bit  m_full [2];
    bit  m_ovr  [2];
    int  n_valid;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    bit          prev_sclk [2];
    bit          prev_sync [2];
    int          nbits     [2];
    logic [15:0] word      [2];
    int          n_frames  [2];
    int          n_ovr     [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int shift_len(input int d);
        return FW * 2 * p_div[d];
    endfunction

    // Frame-level timing model: load when held and the previous frame period has elapsed.
    task automatic model_edge(input int d);
        bit old_full;
        bit idle;
        int k;
        old_full = m_full[d];
        k        = cyc - 1 - m_load[d];
        idle     = !m_has[d] || (k >= shift_len(d) + p_gap[d]);
        m_ovr[d] = 1'b0;
        if (old_full && idle) begin
            m_full[d] = 1'b0;
            m_has[d]  = 1'b1;
            m_load[d] = cyc;
        end
        if (sample_valid) begin
            if (!old_full) begin
                m_full[d] = 1'b1;
                if (d == 0) q0.push_back({p_ctrl[d], sample_in});
                else        q1.push_back({p_ctrl[d], sample_in});
            end else begin
                m_ovr[d] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                m_has[d]     = 1'b0;
                m_full[d]    = 1'b0;
                m_ovr[d]     = 1'b0;
                m_load[d]    = 0;
                prev_sclk[d] = 1'b1;
                prev_sync[d] = 1'b1;
                nbits[d]     = 0;
                word[d]      = '0;
            end
        end else begin
            cyc++;
            if (sample_valid) n_valid++;
            for (int d = 0; d < 2; d++) model_edge(d);
        end
    end

    task automatic cycle_check(input int d);
        int k;
        bit in_shift;
        k        = cyc - m_load[d];
        in_shift = m_has[d] && (k < shift_len(d));
        chk($sformatf("d%0d_ready@%0d", d, cyc), 32'(ready[d]), 32'(!m_full[d]));
        chk($sformatf("d%0d_overrun@%0d", d, cyc), 32'(ovr[d]), 32'(m_ovr[d]));
        chk($sformatf("d%0d_sync_n@%0d", d, cyc), 32'(sync_n[d]), 32'(!in_shift));
        chk($sformatf("d%0d_busy@%0d", d, cyc), 32'(busy[d]),
            32'(m_has[d] && (k < shift_len(d) + p_gap[d])));
        chk($sformatf("d%0d_sclk@%0d", d, cyc), 32'(sclk[d]),
            32'(!(in_shift && (((k / p_div[d]) % 2) == 1))));
    endtask

    // Captures din on each falling sclk and scores the frame when sync_n rises.
    task automatic mon_step(input int d);
        logic [15:0] exp_word;
        int sz;
        if (prev_sync[d] && !sync_n[d]) nbits[d] = 0;
        if (prev_sclk[d] && !sclk[d]) begin
            chk($sformatf("d%0d_fall_in_frame", d), 32'(sync_n[d]), 32'd0);
            word[d] = {word[d][14:0], din[d]};
            nbits[d]++;
        end
        if (!prev_sync[d] && sync_n[d]) begin
            chk($sformatf("d%0d_nbits", d), 32'(nbits[d]), 32'(FW));
            sz = (d == 0) ? q0.size() : q1.size();
            chk($sformatf("d%0d_sb_nonempty", d), 32'(sz != 0), 32'd1);
            if (sz != 0) begin
                exp_word = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("d%0d_frame", d), 32'(word[d]), 32'(exp_word));
            end
            n_frames[d]++;
        end
        if (ovr[d]) n_ovr[d]++;
        prev_sclk[d] = sclk[d];
        prev_sync[d] = sync_n[d];
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                cycle_check(d);
                mon_step(d);
            end
        end
    end

    task automatic send(input logic [11:0] s);
        sample_valid = 1'b1;
        sample_in    = s;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        chk("drain_q", 32'(q0.size() + q1.size()), 32'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_k(input int k);
        for (int i = 0; i < 400; i++) begin
            if (m_has[0] && (cyc - m_load[0] == k)) break;
            @(negedge clk);
        end
        chk("wait_k", 32'(cyc - m_load[0]), 32'(k));
    endtask

    int v_start, f_start [2], o_start [2], nv;

    initial begin
        n_valid      = 0;
        n_frames     = '{0, 0};
        n_ovr        = '{0, 0};
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'h3);
        chk("rst_sync_n", 32'(sync_n), 32'h3);
        chk("rst_din", 32'(din), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(ready), 32'h3);
        chk("rst_overrun", 32'(ovr), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single sample and load latency.
        send(12'hABC);
        chk("lat_sync_1", 32'(sync0), 32'd1);
        @(negedge clk);
        chk("lat_sync_2", 32'(sync0), 32'd0);
        chk("lat_busy", 32'(busy0), 32'd1);
        drain();

        // Two samples at exactly the frame period.
        send(12'h000);
        repeat (130) @(negedge clk);
        send(12'hFFF);
        drain();

        // Valid held every cycle.
        sample_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            sample_in = 12'($urandom);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        drain();

        // Reset mid-frame with the holding register full.
        send(12'h123);
        wait_k(30);
        send(12'h456);
        wait_k(58);
        chk("pre_rst_sync", 32'(sync0), 32'd0);
        chk("pre_rst_ready", 32'(ready0), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("arst_sclk", 32'(sclk0), 32'd1);
        chk("arst_sync_n", 32'(sync0), 32'd1);
        chk("arst_din", 32'(din0), 32'd0);
        chk("arst_ready", 32'(ready0), 32'd1);
        chk("arst_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(12'h321);
        drain();

        // Fast instance pattern (both instances see it).
        send(12'h5A5);
        drain();

        // Random valid pattern.
        v_start = n_valid;
        for (int d = 0; d < 2; d++) begin
            f_start[d] = n_frames[d];
            o_start[d] = n_ovr[d];
        end
        nv = 0;
        while (nv < 10000) begin
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_in    = 12'($urandom);
            if (sample_valid) nv++;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        drain();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_acc_plus_ovr", d),
                32'((n_frames[d] - f_start[d]) + (n_ovr[d] - o_start[d])), 32'(n_valid - v_start));
        end
        chk("valid_count", 32'(n_valid - v_start), 32'd10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
